de_data_reader: RTL and testbench

Reads a fixed-length block of bytes (the encrypted message) from an external synchronous ROM and presents it as a parallel byte array to the RC4 decrypt datapath. It is the read-side counterpart of the decrypted-data writer: it walks addresses 0..DEPTH-1, captures each ROM word after the ROM read latency, and raises done when the whole array is valid. It sits between the encrypted-message ROM and the decrypt core, and is controlled by a start/done handshake from the top-level sequencer.

---
 rtl/de_pkg.sv | 23 ++
 rtl/de_data_reader_if.sv | 41 ++++
 rtl/de_data_reader.sv | 109 ++++++++++
 tb/tb_de_data_reader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/de_pkg.sv
// Shared types and constants for the RC4 decrypt message path.
//   MSG_BYTES   : length of the encrypted message in bytes
//   MSG_ADDR_W  : ROM address width covering MSG_BYTES
//   byte_t      : one message byte
//   msg_array_t : packed view of a whole message
//   rd_state_t  : sequencing states of the message reader
package de_pkg;

  localparam int MSG_BYTES  = 32;
  localparam int MSG_ADDR_W = 5;

  typedef logic [7:0] byte_t;
  typedef byte_t [MSG_BYTES-1:0] msg_array_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } rd_state_t;

endpackage

// File: rtl/de_data_reader_if.sv
// Bundle between the message reader, the encrypted-message ROM and the
// top-level sequencer / decrypt core.
//   start       : sequencer requests a block read
//   busy, done  : reader status
//   rom_address : reader -> ROM read address
//   rom_q       : ROM -> reader read data
//   data_out    : captured message bytes
// slave  : the reader's view; master : the surrounding system's view.
interface de_data_reader_if
  import de_pkg::*;
#(
  parameter int DEPTH  = MSG_BYTES,
  parameter int ADDR_W = MSG_ADDR_W
) ();

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_address;
  logic [7:0]        rom_q;
  byte_t             data_out [DEPTH];

  modport slave (
    input  start,
    input  rom_q,
    output busy,
    output done,
    output rom_address,
    output data_out
  );

  modport master (
    output start,
    output rom_q,
    input  busy,
    input  done,
    input  rom_address,
    input  data_out
  );

endinterface

// File: rtl/de_data_reader.sv
// Reads DEPTH bytes from an external synchronous ROM (addresses 0..DEPTH-1)
// and presents them as a byte array to the decrypt datapath.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : de_data_reader_if.slave
//           start (in), rom_q (in), rom_address (out), data_out (out),
//           busy (out), done (out)
// Each byte takes READ_LATENCY+1 cycles: ISSUE, READ_LATENCY-1 WAIT cycles,
// then CAPTURE. rom_address is the registered byte index and stays stable
// across the whole per-byte window.
module de_data_reader
  import de_pkg::*;
#(
  parameter int DEPTH        = MSG_BYTES,
  parameter int ADDR_W       = MSG_ADDR_W,
  parameter int READ_LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  de_data_reader_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        WAIT_LOAD = 2'(READ_LATENCY - 1);

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_wait_cnt;
  logic              r_busy;
  logic              r_done;
  byte_t             r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_wait_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= ISSUE;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end

        ISSUE: begin
          // With single-cycle ROM latency there is no wait phase at all.
          if (READ_LATENCY == 1) begin
            r_state <= CAPTURE;
          end else begin
            r_state    <= WAIT;
            r_wait_cnt <= WAIT_LOAD;
          end
        end

        WAIT: begin
          if (r_wait_cnt <= 2'd1) begin
            r_state <= CAPTURE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end

        CAPTURE: begin
          r_data[r_idx] <= bus.rom_q;
          // Last-byte test precedes the increment so the index never wraps.
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ISSUE;
          end
        end

        DONE: begin
          // Restart keeps the old array; each byte is overwritten on capture.
          if (bus.start) begin
            r_state <= ISSUE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_address = r_idx;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.data_out    = r_data;

endmodule

// File: tb/tb_de_data_reader.sv
// Self-checking bench for de_data_reader: one instance with the default
// ROM latency (2) and one with READ_LATENCY=1, each fed by a behavioural
// ROM of matching latency. Expected timing is computed from the per-byte
// window length; expected data is the ROM image at read time.
module tb_de_data_reader;
  import de_pkg::*;

  localparam int D    = 32;
  localparam int AW   = 5;
  localparam int RLA  = 2;
  localparam int WA   = RLA + 1;
  localparam int NA   = D * WA;   // busy cycles, done in cycle NA+1
  localparam int RLB  = 1;
  localparam int WB   = RLB + 1;
  localparam int NB   = D * WB;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  de_data_reader_if #(.DEPTH(D), .ADDR_W(AW)) if_a ();
  de_data_reader_if #(.DEPTH(D), .ADDR_W(AW)) if_b ();

  de_data_reader #(.DEPTH(D), .ADDR_W(AW), .READ_LATENCY(RLA)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  de_data_reader #(.DEPTH(D), .ADDR_W(AW), .READ_LATENCY(RLB)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  // Behavioural ROMs: data appears RL clocks after the address is presented.
  logic [7:0] rom_a [D];
  logic [7:0] rom_b [D];
  logic [7:0] pipe_a [RLA];
  logic [7:0] pipe_b;

  always @(posedge clk) begin
    pipe_a[0] <= rom_a[if_a.rom_address];
    pipe_a[1] <= pipe_a[0];
    pipe_b    <= rom_b[if_b.rom_address];
  end
  assign if_a.rom_q = pipe_a[RLA-1];
  assign if_b.rom_q = pipe_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a_cleared();
    check("A_rst_busy", if_a.busy, 0);
    check("A_rst_done", if_a.done, 0);
    check("A_rst_addr", if_a.rom_address, 0);
    for (int i = 0; i < D; i++) check("A_rst_data", if_a.data_out[i], 0);
  endtask

  // Precondition: A is idle or done, time is just after a rising edge.
  // repulse_at: cycle in which start is pulsed again (ignored while busy).
  // abort_at  : cycle in which reset is applied (0 = none).
  task automatic run_a(input int repulse_at, input bit hold, input int abort_at);
    if_a.start = 1'b1;
    tick();
    if (!hold) if_a.start = 1'b0;
    for (int k = 1; k <= NA; k++) begin
      check("A_busy", if_a.busy, 1);
      check("A_done", if_a.done, 0);
      check("A_addr", if_a.rom_address, (k - 1) / WA);
      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_a_cleared();
        return;
      end
      if (k == repulse_at) if_a.start = 1'b1;
      else if (!hold)      if_a.start = 1'b0;
      tick();
    end
    check("A_done_end", if_a.done, 1);
    check("A_busy_end", if_a.busy, 0);
    check("A_addr_end", if_a.rom_address, D - 1);
    for (int i = 0; i < D; i++) check("A_data", if_a.data_out[i], rom_a[i]);
  endtask

  task automatic run_b();
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    for (int k = 1; k <= NB; k++) begin
      check("B_busy", if_b.busy, 1);
      check("B_done", if_b.done, 0);
      check("B_addr", if_b.rom_address, (k - 1) / WB);
      tick();
    end
    check("B_done_end", if_b.done, 1);
    check("B_busy_end", if_b.busy, 0);
    for (int i = 0; i < D; i++) check("B_data", if_b.data_out[i], rom_b[i]);
  endtask

  initial begin
    reset      = 1'b1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    for (int i = 0; i < D; i++) begin
      rom_a[i] = 8'(i) ^ 8'hA5;
      rom_b[i] = 8'hFF - 8'(i);
    end
    tick();
    tick();
    check_a_cleared();
    check("B_rst_busy", if_b.busy, 0);
    check("B_rst_done", if_b.done, 0);
    check("B_rst_addr", if_b.rom_address, 0);
    reset = 1'b0;
    tick();
    check("A_idle_done", if_a.done, 0);

    // Defaults, ROM[i] = i ^ A5.
    run_a(0, 1'b0, 0);
    check("A_d0_A5", if_a.data_out[0], 8'hA5);
    check("A_d31_BA", if_a.data_out[D-1], 8'hBA);
    tick();
    check("A_done_hold", if_a.done, 1);

    // Random image, start re-pulsed mid-run is ignored.
    for (int i = 0; i < D; i++) rom_a[i] = 8'($urandom);
    run_a(40, 1'b0, 0);

    // Reset during byte 10, then a clean full run.
    for (int i = 0; i < D; i++) rom_a[i] = 8'($urandom);
    run_a(0, 1'b0, 3 * 10 + 2);
    tick();
    check("A_post_rst_done", if_a.done, 0);
    run_a(0, 1'b0, 0);

    // Restart from DONE with a new image.
    for (int i = 0; i < D; i++) rom_a[i] = 8'h3C;
    run_a(0, 1'b0, 0);
    for (int i = 0; i < D; i++) check("A_3C", if_a.data_out[i], 8'h3C);

    // start held high: back-to-back runs, done high one cycle each.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < D; i++) rom_a[i] = 8'($urandom);
      run_a(0, 1'b1, 0);
    end
    if_a.start = 1'b0;
    tick();
    check("A_held_release_done", if_a.done, 1);
    check("A_held_release_busy", if_a.busy, 0);

    // READ_LATENCY=1 instance: ROM[i] = FF - i, then a random image.
    run_b();
    check("B_d0_FF", if_b.data_out[0], 8'hFF);
    check("B_d31_E0", if_b.data_out[D-1], 8'hE0);
    for (int i = 0; i < D; i++) rom_b[i] = 8'($urandom);
    run_b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
